// File: rtl/vproc_queue_mp.sv
// Multi-port in-order FIFO: up to ENQ_N pushes and DEQ_N pops per cycle, occupancy count, flush.
// Define VPROC_QUEUE_MP_FLAGS_EN to build the any/all reduction over valid entries.
module vproc_queue_mp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ENQ_N = 2,
  parameter int unsigned DEQ_N = 2
) (
  input  logic                       clk_i,
  input  logic                       async_rst_ni,
  input  logic                       flush_i,
  output logic [ENQ_N-1:0]           enq_ready_o,
  input  logic [ENQ_N-1:0]           enq_valid_i,
  input  logic [ENQ_N*WIDTH-1:0]     enq_data_i,
  output logic [DEQ_N-1:0]           deq_valid_o,
  input  logic [DEQ_N-1:0]           deq_ready_i,
  output logic [DEQ_N*WIDTH-1:0]     deq_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [WIDTH-1:0]           flags_any_o,
  output logic [WIDTH-1:0]           flags_all_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [SW-1:0] sum_t;

  if (WIDTH < 1 || DEPTH < 2 || ENQ_N < 1 || ENQ_N > DEPTH || DEQ_N < 1 || DEQ_N > DEPTH)
  begin : g_param_check
    $error("vproc_queue_mp: illegal parameter combination");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t rd_ptr_q, wr_ptr_q;
  cnt_t cnt_q, push_n, pop_n;

  // Single compare-and-subtract wrap; base < DEPTH and inc <= DEPTH keep the sum below 2*DEPTH.
  function automatic ptr_t wrap_add(input ptr_t base, input cnt_t inc);
    sum_t sum;
    sum = sum_t'(base) + sum_t'(inc);
    if (sum >= sum_t'(DEPTH)) sum = sum - sum_t'(DEPTH);
    return ptr_t'(sum);
  endfunction

  always_comb begin
    for (int i = 0; i < ENQ_N; i++) enq_ready_o[i] = (cnt_t'(DEPTH) - cnt_q) > cnt_t'(i);
    for (int j = 0; j < DEQ_N; j++) begin
      deq_valid_o[j] = cnt_q > cnt_t'(j);
      deq_data_o[j*WIDTH +: WIDTH] = mem_q[wrap_add(rd_ptr_q, cnt_t'(j))];
    end
  end

  always_comb begin
    logic run;
    push_n = '0;
    run    = 1'b1;
    for (int i = 0; i < ENQ_N; i++) begin
      run = run & enq_valid_i[i] & enq_ready_o[i];
      if (run) push_n = push_n + cnt_t'(1);
    end
  end

  always_comb begin
    logic run;
    pop_n = '0;
    run   = 1'b1;
    for (int j = 0; j < DEQ_N; j++) begin
      run = run & deq_valid_o[j] & deq_ready_i[j];
      if (run) pop_n = pop_n + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wrap_add(wr_ptr_q, push_n);
      rd_ptr_q <= wrap_add(rd_ptr_q, pop_n);
      cnt_q    <= cnt_q + push_n - pop_n;
    end
  end

  // Storage carries no reset; stale slots are never observable because cnt gates every read.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int k = 0; k < ENQ_N; k++) begin
        if (cnt_t'(k) < push_n) mem_q[wrap_add(wr_ptr_q, cnt_t'(k))] <= enq_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign count_o = cnt_q;

`ifdef VPROC_QUEUE_MP_FLAGS_EN
  always_comb begin
    flags_any_o = '0;
    flags_all_o = '1;
    for (int k = 0; k < DEPTH; k++) begin
      if (cnt_t'(k) < cnt_q) begin
        flags_any_o |= mem_q[wrap_add(rd_ptr_q, cnt_t'(k))];
        flags_all_o &= mem_q[wrap_add(rd_ptr_q, cnt_t'(k))];
      end
    end
  end
`else
  assign flags_any_o = '0;
  assign flags_all_o = '1;
`endif

endmodule

// File: tb/tb_vproc_queue_mp.sv
// Scoreboard bench for vproc_queue_mp: 8-deep 2x2 instance plus a 5-deep 1x1 instance for wrap.
module tb_vproc_queue_mp;

`ifdef VPROC_QUEUE_MP_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic async_rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // DEPTH=8, ENQ_N=2, DEQ_N=2
  logic        flush8 = 1'b0;
  logic [1:0]  enq_ready8, enq_valid8 = '0, deq_valid8, deq_ready8 = '0;
  logic [15:0] enq_data8 = '0, deq_data8;
  logic [3:0]  count8;
  logic [7:0]  any8, all8;

  // DEPTH=5, ENQ_N=1, DEQ_N=1
  logic        flush5 = 1'b0;
  logic [0:0]  enq_ready5, enq_valid5 = '0, deq_valid5, deq_ready5 = '0;
  logic [7:0]  enq_data5 = '0, deq_data5;
  logic [2:0]  count5;
  logic [7:0]  any5, all5;

  vproc_queue_mp #(.WIDTH(8), .DEPTH(8), .ENQ_N(2), .DEQ_N(2)) u_dut (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni), .flush_i(flush8),
    .enq_ready_o(enq_ready8), .enq_valid_i(enq_valid8), .enq_data_i(enq_data8),
    .deq_valid_o(deq_valid8), .deq_ready_i(deq_ready8), .deq_data_o(deq_data8),
    .count_o(count8), .flags_any_o(any8), .flags_all_o(all8)
  );

  vproc_queue_mp #(.WIDTH(8), .DEPTH(5), .ENQ_N(1), .DEQ_N(1)) u_dut5 (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni), .flush_i(flush5),
    .enq_ready_o(enq_ready5), .enq_valid_i(enq_valid5), .enq_data_i(enq_data5),
    .deq_valid_o(deq_valid5), .deq_ready_i(deq_ready5), .deq_data_o(deq_data5),
    .count_o(count5), .flags_any_o(any5), .flags_all_o(all5)
  );

  logic [7:0] q8[$];
  logic [7:0] q5[$];
  int cnt8 = 0;
  int cnt5 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_any();
    logic [7:0] r = 8'h00;
    for (int j = 0; j < cnt8; j++) r |= q8[j];
    return FLAGS_EN ? r : 8'h00;
  endfunction

  function automatic logic [7:0] m_all();
    logic [7:0] r = 8'hFF;
    for (int j = 0; j < cnt8; j++) r &= q8[j];
    return FLAGS_EN ? r : 8'hFF;
  endfunction

  // Check the visible state against the model, then apply one cycle of stimulus.
  task automatic step8(input logic [1:0] ev, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] dr, input logic fl);
    int p, q, freen;
    @(posedge clk_i); #1;
    freen = 8 - cnt8;
    chk("count8", 32'(count8), 32'(cnt8));
    chk("enq_ready8", 32'(enq_ready8), {30'd0, freen > 1, freen > 0});
    chk("deq_valid8", 32'(deq_valid8), {30'd0, cnt8 > 1, cnt8 > 0});
    chk("flags_any8", 32'(any8), 32'(m_any()));
    chk("flags_all8", 32'(all8), 32'(m_all()));
    for (int j = 0; j < 2; j++)
      if (j < cnt8) chk("deq_data8", 32'(deq_data8[j*8 +: 8]), 32'(q8[j]));
    enq_valid8 = ev;
    enq_data8  = {d1, d0};
    deq_ready8 = dr;
    flush8     = fl;
    p = 0;
    if (ev[0] && freen > 0) p = 1;
    if (p == 1 && ev[1] && freen > 1) p = 2;
    q = 0;
    if (dr[0] && cnt8 > 0) q = 1;
    if (q == 1 && dr[1] && cnt8 > 1) q = 2;
    if (fl) begin
      q8.delete();
      cnt8 = 0;
    end else begin
      if (p > 0) q8.push_back(d0);
      if (p > 1) q8.push_back(d1);
      cnt8 = cnt8 + p - q;
    end
  endtask

  task automatic step5(input logic v, input logic [7:0] d, input logic r);
    int p, q;
    @(posedge clk_i); #1;
    chk("count5", 32'(count5), 32'(cnt5));
    chk("enq_ready5", 32'(enq_ready5), 32'(cnt5 < 5));
    chk("deq_valid5", 32'(deq_valid5), 32'(cnt5 > 0));
    if (cnt5 > 0) chk("deq_data5", 32'(deq_data5), 32'(q5[0]));
    enq_valid5 = v;
    enq_data5  = d;
    deq_ready5 = r;
    p = (v && cnt5 < 5) ? 1 : 0;
    q = (r && cnt5 > 0) ? 1 : 0;
    if (p > 0) q5.push_back(d);
    cnt5 = cnt5 + p - q;
  endtask

  // Monitors: pop the scoreboard whenever the DUT hands off an entry.
  always @(negedge clk_i) begin
    if (async_rst_ni) begin
      for (int j = 0; j < 2; j++) begin
        if (deq_valid8[j] && deq_ready8[j] && (j == 0 || (deq_valid8[0] && deq_ready8[0]))) begin
          if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop8_empty: lane %0d popped %0h with nothing expected", j, deq_data8[j*8 +: 8]);
          end else begin
            chk("pop8_data", 32'(deq_data8[j*8 +: 8]), 32'(q8.pop_front()));
          end
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (async_rst_ni) begin
      chk("count5_max", 32'(count5 <= 3'd5), 32'd1);
      if (deq_valid5[0] && deq_ready5[0]) begin
        if (q5.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop5_empty: popped %0h with nothing expected", deq_data5);
        end else begin
          chk("pop5_data", 32'(deq_data5), 32'(q5.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    repeat (2) @(posedge clk_i);
    #2 async_rst_ni = 1'b1;

    // Reset values, then fill with 0x01..0x08
    step8(2'b11, 8'h01, 8'h02, 2'b00, 1'b0);
    step8(2'b11, 8'h03, 8'h04, 2'b00, 1'b0);
    step8(2'b11, 8'h05, 8'h06, 2'b00, 1'b0);
    step8(2'b11, 8'h07, 8'h08, 2'b00, 1'b0);
    step8(2'b00, 8'h00, 8'h00, 2'b01, 1'b0);   // full; pop one
    step8(2'b11, 8'hAA, 8'hBB, 2'b00, 1'b0);   // count 7: only lane 0 accepted
    step8(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    chk("full_again", 32'(count8), 32'd8);
    repeat (3) step8(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);

    // Steady state at four entries across pointer wrap
    step8(2'b11, 8'h10, 8'h11, 2'b00, 1'b0);
    step8(2'b11, 8'h12, 8'h13, 2'b00, 1'b0);
    d = 8'h14;
    for (int i = 0; i < 10; i++) begin
      step8(2'b11, d, d + 8'h01, 2'b11, 1'b0);
      d = d + 8'h02;
    end
    step8(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    step8(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);

    // Flags over 0x81, 0x01, 0x03, then flush with a concurrent push
    step8(2'b11, 8'h81, 8'h01, 2'b00, 1'b0);
    step8(2'b01, 8'h03, 8'h00, 2'b00, 1'b0);
    step8(2'b11, 8'h55, 8'h66, 2'b00, 1'b1);
    chk("flags_any_hand", 32'(any8), FLAGS_EN ? 32'h83 : 32'h00);
    chk("flags_all_hand", 32'(all8), FLAGS_EN ? 32'h01 : 32'hFF);
    step8(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    chk("post_flush_cnt", 32'(count8), 32'd0);

    // Odd occupancy: pop two of three, then ask for two with one left
    step8(2'b11, 8'h41, 8'h42, 2'b00, 1'b0);
    step8(2'b01, 8'h43, 8'h00, 2'b00, 1'b0);
    step8(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    step8(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);

    // Asynchronous reset with a push in flight
    step8(2'b11, 8'h21, 8'h22, 2'b00, 1'b0);
    step8(2'b11, 8'h23, 8'h24, 2'b00, 1'b0);
    #2 async_rst_ni = 1'b0;
    q8.delete();
    cnt8 = 0;
    @(posedge clk_i); #3;
    enq_valid8 = 2'b00;
    async_rst_ni = 1'b1;
    step8(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    step8(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);

    // DEPTH=5: one push per cycle with pops delayed by one cycle
    for (int i = 0; i < 12; i++) step5(1'b1, 8'h30 + 8'(i), i > 0);
    step5(1'b0, 8'h00, 1'b1);
    step5(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step5(1'b1, 8'h50 + 8'(i), 1'b0);
    step5(1'b0, 8'h00, 1'b0);
    chk("full5", 32'(count5), 32'd5);
    for (int i = 0; i < 5; i++) step5(1'b0, 8'h00, 1'b1);
    step5(1'b0, 8'h00, 1'b0);

    @(posedge clk_i); #1;
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q5_drained", 32'(q5.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vproc_queue_mp.md
Name: vproc_queue_mp

Overview:
Multi-port in-order FIFO. Accepts up to ENQ_N entries and releases up to DEQ_N entries per cycle. Also provides an occupancy count, a synchronous flush, and optional any/all flag reduction over valid entries. Serves vector-unit paths where decode and dispatch run wider than one instruction per cycle.

Parameters:
WIDTH, 8, data element width in bits
DEPTH, 8, number of entries; any value >= 2, power of two not required
ENQ_N, 2, enqueue lanes per cycle; 1 <= ENQ_N <= DEPTH
DEQ_N, 2, dequeue lanes per cycle; 1 <= DEQ_N <= DEPTH
(elaboration error if any constraint is violated)

Ports:
clk_i  in  1  clock
async_rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of queue contents
enq_ready_o  out  ENQ_N  lane i may accept an entry
enq_valid_i  in  ENQ_N  lane i offers an entry; must be a contiguous prefix from lane 0
enq_data_i  in  ENQ_N*WIDTH  lane i data in bits [i*WIDTH +: WIDTH]
deq_valid_o  out  DEQ_N  lane j presents a valid entry
deq_ready_i  in  DEQ_N  lane j consumes; must be a contiguous prefix from lane 0
deq_data_o  out  DEQ_N*WIDTH  lane j data = entry (rd_ptr+j) mod DEPTH
count_o  out  $clog2(DEPTH+1)  number of valid entries (registered)
flags_any_o  out  WIDTH  bitwise OR over valid entries
flags_all_o  out  WIDTH  bitwise AND over valid entries

Behaviour:
- Clock and reset: one clock `clk_i`. Reset `async_rst_ni` is asynchronous, active-low.
- State: rd_ptr, wr_ptr in 0..DEPTH-1; cnt in 0..DEPTH. Data array is not reset.
- Reset values:
  - rd_ptr = wr_ptr = cnt = 0.
  - enq_ready_o all 1; deq_valid_o all 0; count_o = 0.
  - flags_any_o = 0; flags_all_o = all 1.
- enq_ready_o[i] = (DEPTH - cnt) > i. Depends only on registered cnt; a same-cycle pop never frees space in that cycle, so there is no ready/ready combinational path.
- deq_valid_o[j] = cnt > j. No flow-through; an entry pushed in cycle t is first visible at a dequeue lane in cycle t+1.
- Push count P = length of the leading run of lanes with enq_valid_i & enq_ready_o. Lanes after the first gap are ignored (illegal stimulus).
- Enqueue lane k < P writes slot (wr_ptr+k) mod DEPTH.
- Pop count Q = length of the leading run of lanes with deq_valid_o & deq_ready_i.
- Next-state updates:
  - wr_ptr += P, rd_ptr += Q, both mod DEPTH.
  - Wrap computed by compare-and-subtract; valid for non-power-of-two DEPTH.
  - cnt += P - Q.
- Simultaneous push and pop in the same cycle are both honoured. Full (cnt = DEPTH) and empty (cnt = 0) are unambiguous via cnt.
- deq_data_o for invalid lanes is don't-care.
- flush_i: next cycle rd_ptr = wr_ptr = cnt = 0. It overrides any push or pop in the same cycle; no entry is written that cycle. Asynchronous reset mid-operation behaves identically to flush, including discarding in-flight pushes.
- Flags:
  - Reduce over slots (rd_ptr+k) mod DEPTH, k < cnt, using registered state only (this cycle's push/pop is excluded).
  - Empty queue: any = 0, all = all 1.

Optional Feature:
- Macro VPROC_QUEUE_MP_FLAGS_EN.
- Defined: flags_any_o and flags_all_o are computed as specified above.
- Undefined: the reduction logic is not built; flags_any_o is tied to 0 and flags_all_o to all 1. Ports remain present.

Test Plan:
- Reset (DEPTH=8, ENQ_N=2, DEQ_N=2) -> enq_ready_o=2'b11, deq_valid_o=2'b00, count_o=0, flags_any_o=0x00, flags_all_o=0xFF.
- Push pairs 0x01..0x08 over 4 cycles with no pops -> count_o=8, enq_ready_o=2'b00, deq_valid_o=2'b11, deq_data_o lanes = 0x01, 0x02.
- count_o=7 with enq_valid_i=2'b11 -> enq_ready_o=2'b01, exactly one entry accepted, count_o=8 next cycle; lane 1 data is not stored.
- At count_o=4, push 2 and pop 2 every cycle for 10 cycles with an incrementing data pattern -> count_o stays 4; output order is strictly incrementing across pointer wrap.
- DEPTH=5: 1 push/cycle with 1-cycle-delayed pops for 12 cycles -> pointers wrap 4->0; dequeued sequence equals enqueued sequence; count_o never exceeds 5.
- Entries 0x81, 0x01, 0x03 queued -> flags_any_o=0x83, flags_all_o=0x01. Then flush_i=1 with enq_valid_i=2'b11 -> next cycle count_o=0, deq_valid_o=2'b00, flags_any_o=0x00, flags_all_o=0xFF.
